icache_refill_ctrl: RTL and testbench
=====================================

Name: icache_refill_ctrl

Overview:
Sequences the direct-mapped instruction cache.
- Each fetch request probes the cache. A hit is returned combinationally.
- On a miss, the block wins the byte-wide memory bus from the memory arbiter and reads 4 consecutive bytes.
- It assembles them little-endian, writes the 32-bit word into the cache through the update port, and forwards the word to the fetch stage.
- It sits between the IF stage, the instruction cache and the memory arbiter.

Parameters:
XLEN, 32, address and instruction width.
MEM_RD_LATENCY, 1, cycles from mem_a/mem_rd_en to valid mem_din; legal values 1..2.

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous reset, active-high
rdy_in  in  1  global pause; when low, all state and outputs hold
flush  in  1  IF redirect (branch mispredict); aborts any miss in progress
fetch_valid  in  1  IF requests the instruction at fetch_addr
fetch_addr  in  XLEN  fetch address, 2-byte aligned (RV32C)
fetch_ready  out  1  fetch_inst valid this cycle
fetch_inst  out  XLEN  instruction word
cache_addr  out  XLEN  cache probe address (= fetch_addr)
cache_hit  in  1  cache hit indication
cache_data  in  XLEN  cache read data
cache_update  out  1  one-cycle cache write strobe
cache_update_addr  out  XLEN  address of the word being written
cache_update_data  out  XLEN  word being written
mem_req  out  1  bus request to the arbiter
mem_grant  in  1  arbiter grant; held by the arbiter while mem_req stays high
mem_rd_en  out  1  byte read enable
mem_a  out  XLEN  byte address
mem_din  in  8  read byte, valid MEM_RD_LATENCY cycles after issue

Behaviour:
- Reset (async, rst_in=1): state=IDLE; byte counters=0; every output=0; miss_addr=0; data buffer=0.
- Pause: when rdy_in=0 no register changes, and mem_rd_en is forced to 0.
- States: IDLE, REQ, READ, FILL.
- IDLE:
  - cache_addr=fetch_addr.
  - fetch_valid & cache_hit & !flush -> fetch_ready=1 and fetch_inst=cache_data in the same cycle (0-cycle hit).
  - fetch_valid & !cache_hit & !flush -> latch miss_addr=fetch_addr; go to REQ.
- REQ:
  - mem_req=1.
  - mem_grant -> go to READ with issue_cnt=0 and recv_cnt=0.
  - flush -> IDLE; mem_req drops next cycle.
- READ:
  - mem_req=1.
  - While issue_cnt<4: mem_rd_en=1, mem_a=miss_addr+issue_cnt (mod 2^32 wrap); issue_cnt increments each cycle.
  - Byte recv_cnt is captured from mem_din MEM_RD_LATENCY cycles after its issue into buffer[8*recv_cnt+:8].
  - When recv_cnt reaches 4 -> FILL.
  - Minimum miss latency: 4+MEM_RD_LATENCY cycles in READ.
  - flush -> IDLE immediately; no cache write; outstanding bytes are discarded.
- FILL (exactly one cycle):
  - cache_update=1, cache_update_addr=miss_addr, cache_update_data=buffer.
  - If fetch_valid & fetch_addr==miss_addr & !flush: fetch_ready=1, fetch_inst=buffer (bypass).
  - mem_req=0; next state IDLE.
  - flush in FILL still writes the cache but suppresses fetch_ready.
- fetch_ready is never asserted outside IDLE hit or the FILL bypass.
- fetch_addr changes during REQ/READ are ignored; the fill completes for miss_addr.
- No new miss is accepted in the FILL cycle, so back-to-back misses cost one IDLE cycle.
- Reset mid-fill: no cache_update is issued, and the bus is released asynchronously.

Optional Feature:
ICACHE_STATS_EN
- Defined: adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - hit_cnt increments on each IDLE hit handshake (rdy_in=1).
  - miss_cnt increments on each IDLE->REQ transition.
  - Both wrap at 2^32 and reset to 0.
- Undefined: no ports and no counter logic.

Decomposition:
- Shared package cpu_defs: XLEN, state encoding (IDLE=0, REQ=1, READ=2, FILL=3), FILL_BYTES=4.
- One natural sub-module: refill_byte_gather. It holds recv_cnt, the latency-delay pipe of the issue strobe, and the 32-bit assembly buffer, and asserts done when 4 bytes have been captured.

Test Plan:
- Hit: preload cache 0x00000010 -> 0x00A00093; fetch_valid, addr 0x10 -> fetch_ready=1 in the same cycle, fetch_inst=0x00A00093, mem_req stays 0.
- Miss fill: bytes at 0x20..0x23 = 0x13,0x05,0x10,0x00; fetch 0x20; grant after 2 cycles -> mem_a 0x20..0x23 on consecutive cycles; FILL: cache_update=1, addr 0x20, data 0x00100513, fetch_ready=1.
- Flush in READ after 2 bytes -> IDLE next cycle; cache_update never asserted; mem_req=0.
- rdy_in low for 3 cycles mid-READ -> mem_rd_en=0 during the pause; the same 4-byte sequence resumes; final data is correct.
- Wrap: fetch 0xFFFFFFFE miss -> mem_a sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000, 0x00000001.
- Reset asserted mid-READ -> all outputs 0 immediately (async); after release, the fetch at addr 0x20 restarts as a miss.

Source files
------------

// File: rtl/icache_refill_ctrl_pkg.sv
// Shared definitions for the instruction-cache refill controller: widths,
// refill FSM encoding and the number of bytes gathered per cache word.
package cpu_defs;

    localparam int XLEN       = 32;
    localparam int FILL_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        READ = 2'd2,
        FILL = 2'd3
    } refill_state_e;

endpackage

// File: rtl/icache_refill_ctrl_refill_byte_gather.sv
// Collects the bytes returned by the byte-wide memory bus into one
// little-endian word, delaying each issue strobe by the read latency.
module refill_byte_gather
    import cpu_defs::*;
#(
    parameter int LAT = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      en_i,
    input  logic                      clear_i,
    input  logic                      issue_i,
    input  logic [7:0]                din_i,
    output logic                      done_o,
    output logic [8*FILL_BYTES-1:0]   word_o
);

    logic [2:0]              recv_cnt_q, recv_cnt_d;
    logic [LAT-1:0]          pipe_q, pipe_d;
    logic [8*FILL_BYTES-1:0] buf_q, buf_d;
    logic                    cap;

    always_comb begin
        recv_cnt_d = recv_cnt_q;
        buf_d      = buf_q;
        pipe_d     = (pipe_q << 1) | LAT'(issue_i);
        cap        = pipe_q[LAT-1] && !clear_i;
        // The buffer survives a clear so the FILL cycle can still present it.
        if (clear_i) begin
            recv_cnt_d = 3'd0;
            pipe_d     = '0;
        end else if (cap) begin
            buf_d[8*recv_cnt_q[1:0] +: 8] = din_i;
            recv_cnt_d = recv_cnt_q + 3'd1;
        end
        done_o = cap && (recv_cnt_q == 3'(FILL_BYTES - 1));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            recv_cnt_q <= 3'd0;
            pipe_q     <= '0;
            buf_q      <= '0;
        end else if (en_i) begin
            recv_cnt_q <= recv_cnt_d;
            pipe_q     <= pipe_d;
            buf_q      <= buf_d;
        end
    end

    assign word_o = buf_q;

endmodule

// File: rtl/icache_refill_ctrl.sv
// Direct-mapped I-cache refill sequencer: 0-cycle hits, byte-wide 4-byte
// refill on miss with FILL bypass. Optional hit/miss counters: ICACHE_STATS_EN.
module icache_refill_ctrl
    import cpu_defs::*;
#(
    parameter int XLEN           = cpu_defs::XLEN,
    parameter int MEM_RD_LATENCY = 1
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            rdy_in,
    input  logic            flush,
    input  logic            fetch_valid,
    input  logic [XLEN-1:0] fetch_addr,
    output logic            fetch_ready,
    output logic [XLEN-1:0] fetch_inst,
    output logic [XLEN-1:0] cache_addr,
    input  logic            cache_hit,
    input  logic [XLEN-1:0] cache_data,
    output logic            cache_update,
    output logic [XLEN-1:0] cache_update_addr,
    output logic [XLEN-1:0] cache_update_data,
    output logic            mem_req,
    input  logic            mem_grant,
    output logic            mem_rd_en,
    output logic [XLEN-1:0] mem_a,
    input  logic [7:0]      mem_din
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]     hit_cnt,
    output logic [31:0]     miss_cnt
`endif
);

    refill_state_e   state_q, state_d;
    logic [XLEN-1:0] miss_addr_q, miss_addr_d;
    logic [2:0]      issue_cnt_q, issue_cnt_d;
    logic            gather_clear;
    logic            gather_done;
    logic [31:0]     gather_word;

    assign gather_clear = (state_q != READ) || flush;

    refill_byte_gather #(
        .LAT (MEM_RD_LATENCY)
    ) u_gather (
        .clk_i   (clk_in),
        .rst_i   (rst_in),
        .en_i    (rdy_in),
        .clear_i (gather_clear),
        .issue_i (mem_rd_en),
        .din_i   (mem_din),
        .done_o  (gather_done),
        .word_o  (gather_word)
    );

    always_comb begin
        state_d           = state_q;
        miss_addr_d       = miss_addr_q;
        issue_cnt_d       = issue_cnt_q;
        fetch_ready       = 1'b0;
        fetch_inst        = '0;
        cache_addr        = '0;
        cache_update      = 1'b0;
        cache_update_addr = '0;
        cache_update_data = '0;
        mem_req           = 1'b0;
        mem_rd_en         = 1'b0;
        mem_a             = '0;
        // Outputs read as zero while reset is held, even though IDLE would
        // otherwise pass fetch_addr straight through.
        if (!rst_in) begin
            unique case (state_q)
                IDLE: begin
                    cache_addr = fetch_addr;
                    if (fetch_valid && !flush) begin
                        if (cache_hit) begin
                            fetch_ready = rdy_in;
                            fetch_inst  = rdy_in ? cache_data : '0;
                        end else begin
                            miss_addr_d = fetch_addr;
                            state_d     = REQ;
                        end
                    end
                end
                REQ: begin
                    mem_req = 1'b1;
                    if (flush) begin
                        state_d = IDLE;
                    end else if (mem_grant) begin
                        state_d     = READ;
                        issue_cnt_d = 3'd0;
                    end
                end
                READ: begin
                    mem_req = 1'b1;
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        if (issue_cnt_q < 3'(FILL_BYTES)) begin
                            mem_rd_en   = rdy_in;
                            mem_a       = miss_addr_q + XLEN'(issue_cnt_q);
                            issue_cnt_d = issue_cnt_q + 3'd1;
                        end
                        if (gather_done) state_d = FILL;
                    end
                end
                FILL: begin
                    cache_update      = rdy_in;
                    cache_update_addr = miss_addr_q;
                    cache_update_data = gather_word;
                    if (fetch_valid && (fetch_addr == miss_addr_q) && !flush) begin
                        fetch_ready = rdy_in;
                        fetch_inst  = rdy_in ? gather_word : '0;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            issue_cnt_q <= 3'd0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

`ifdef ICACHE_STATS_EN
    logic        hit_evt, miss_evt;
    logic [31:0] hit_cnt_q, miss_cnt_q;

    assign hit_evt  = (state_q == IDLE) && fetch_valid && cache_hit && !flush;
    assign miss_evt = (state_q == IDLE) && fetch_valid && !cache_hit && !flush;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else if (rdy_in) begin
            if (hit_evt)  hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_evt) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed + randomized bench for icache_refill_ctrl with a behavioural
// cache/memory environment and an expected-address queue.
module tb_icache_refill_ctrl;

    logic        clk;
    logic        rst;
    logic        rdy_in;
    logic        flush;
    logic        fetch_valid;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic [31:0] fetch_inst;
    logic [31:0] cache_addr;
    logic        cache_hit;
    logic [31:0] cache_data;
    logic        cache_update;
    logic [31:0] cache_update_addr;
    logic [31:0] cache_update_data;
    logic        mem_req;
    logic        mem_grant;
    logic        mem_rd_en;
    logic [31:0] mem_a;
    logic [7:0]  mem_din;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    bit   [31:0] c_vld;
    logic [31:0] c_tag [32];
    logic [31:0] c_dat [32];
    logic        pre_we;
    logic [31:0] pre_addr;
    logic [31:0] pre_data;

    icache_refill_ctrl dut (
        .clk_in            (clk),
        .rst_in            (rst),
        .rdy_in            (rdy_in),
        .flush             (flush),
        .fetch_valid       (fetch_valid),
        .fetch_addr        (fetch_addr),
        .fetch_ready       (fetch_ready),
        .fetch_inst        (fetch_inst),
        .cache_addr        (cache_addr),
        .cache_hit         (cache_hit),
        .cache_data        (cache_data),
        .cache_update      (cache_update),
        .cache_update_addr (cache_update_addr),
        .cache_update_data (cache_update_data),
        .mem_req           (mem_req),
        .mem_grant         (mem_grant),
        .mem_rd_en         (mem_rd_en),
        .mem_a             (mem_a),
        .mem_din           (mem_din)
`ifdef ICACHE_STATS_EN
        ,
        .hit_cnt           (hit_cnt),
        .miss_cnt          (miss_cnt)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- environment models ----------------
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [7:0] t;
        case (a)
            32'h20: return 8'h13;
            32'h21: return 8'h05;
            32'h22: return 8'h10;
            32'h23: return 8'h00;
            default: begin
                t = a[7:0] * 8'd7;
                return t ^ a[15:8] ^ a[31:24] ^ 8'hA5;
            end
        endcase
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        if (a == 32'h10) return 32'h00A00093;
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return c_vld[a[5:1]] && (c_tag[a[5:1]] == a);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) mem_din <= 8'h00;
        else if (mem_rd_en) mem_din <= mem_byte(mem_a);
    end

    always @(posedge clk) begin
        if (pre_we) begin
            c_vld[pre_addr[5:1]] <= 1'b1;
            c_tag[pre_addr[5:1]] <= pre_addr;
            c_dat[pre_addr[5:1]] <= pre_data;
        end else if (cache_update) begin
            c_vld[cache_update_addr[5:1]] <= 1'b1;
            c_tag[cache_update_addr[5:1]] <= cache_update_addr;
            c_dat[cache_update_addr[5:1]] <= cache_update_data;
        end
    end

    always_comb begin
        cache_hit  = c_vld[cache_addr[5:1]] && (c_tag[cache_addr[5:1]] == cache_addr);
        cache_data = cache_hit ? c_dat[cache_addr[5:1]] : 32'h0;
    end

    // ---------------- driver / check tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk(tag, 32'(obs), 32'(exp));
    endtask

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk1({tag, "_ready"}, fetch_ready, 1'b0);
        chk({tag, "_inst"}, fetch_inst, 32'h0);
        chk({tag, "_caddr"}, cache_addr, 32'h0);
        chk1({tag, "_upd"}, cache_update, 1'b0);
        chk1({tag, "_req"}, mem_req, 1'b0);
        chk1({tag, "_rd"}, mem_rd_en, 1'b0);
        chk({tag, "_mema"}, mem_a, 32'h0);
    endtask

    // mode 0: complete fetch, 1: flush after two issues, 2: reset after two issues
    task automatic do_fetch(input logic [31:0] addr, input int gdelay, input int mode,
                            input int pause_after);
        logic [31:0] w;
        logic [31:0] ea;
        int n, rd_cycles;
        bit done, paused;
        w = ref_word(addr);
        n = 0; rd_cycles = 0; done = 0; paused = 0;
        fetch_valid = 1'b1;
        fetch_addr  = addr;
        settle();
        chk("cache_addr", cache_addr, addr);
        if (model_hit(addr)) begin
            chk1("hit_ready", fetch_ready, 1'b1);
            chk("hit_inst", fetch_inst, w);
            chk1("hit_req", mem_req, 1'b0);
            tick();
            fetch_valid = 1'b0;
            settle();
            chk1("hit_after_req", mem_req, 1'b0);
            return;
        end
        chk1("miss_ready", fetch_ready, 1'b0);
        tick();
        fetch_addr  = $urandom();
        fetch_valid = 1'($urandom_range(0, 1));
        settle();
        for (int i = 0; i < gdelay; i++) begin
            chk1("req_wait", mem_req, 1'b1);
            chk1("req_rd", mem_rd_en, 1'b0);
            tick();
            settle();
        end
        mem_grant = 1'b1;
        settle();
        chk1("req_grant", mem_req, 1'b1);
        exp_q.delete();
        for (int k = 0; k < 4; k++) exp_q.push_back(addr + 32'(k));
        for (int c = 0; c < 40 && !done; c++) begin
            tick();
            if (!paused && pause_after > 0 && n == pause_after) begin
                paused = 1;
                rdy_in = 1'b0;
                for (int p = 0; p < 3; p++) begin
                    settle();
                    chk1("pause_rd", mem_rd_en, 1'b0);
                    chk1("pause_req", mem_req, 1'b1);
                    chk1("pause_ready", fetch_ready, 1'b0);
                    tick();
                end
                rdy_in = 1'b1;
            end
            if (n == 4) begin
                fetch_valid = 1'b1;
                fetch_addr  = addr;
            end
            if (mode == 1 && n == 2) begin
                flush = 1'b1;
                settle();
                tick();
                flush       = 1'b0;
                fetch_valid = 1'b0;
                mem_grant   = 1'b0;
                settle();
                chk1("flush_req", mem_req, 1'b0);
                for (int k = 0; k < 4; k++) begin
                    chk1("flush_upd", cache_update, 1'b0);
                    chk1("flush_ready", fetch_ready, 1'b0);
                    chk1("flush_rd", mem_rd_en, 1'b0);
                    tick();
                    settle();
                end
                return;
            end
            if (mode == 2 && n == 2) begin
                settle();
                rst = 1'b1;
                #1;
                check_all_zero("rst_mid");
                tick();
                rst         = 1'b0;
                mem_grant   = 1'b0;
                fetch_valid = 1'b0;
                settle();
                chk1("rst_after_req", mem_req, 1'b0);
                return;
            end
            settle();
            if (cache_update) begin
                chk("upd_addr", cache_update_addr, addr);
                chk("upd_data", cache_update_data, w);
                chk1("fill_ready", fetch_ready, 1'b1);
                chk("fill_inst", fetch_inst, w);
                chk1("fill_req", mem_req, 1'b0);
                chk("issued", 32'(n), 32'd4);
                chk("read_cycles", 32'(rd_cycles), 32'd5);
                done = 1;
            end else begin
                rd_cycles++;
                chk1("read_ready", fetch_ready, 1'b0);
                chk1("read_req", mem_req, 1'b1);
                if (mem_rd_en) begin
                    chk1("issue_bound", n < 4, 1'b1);
                    ea = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                    chk("mem_a", mem_a, ea);
                    n++;
                end
            end
        end
        chk1("fill_seen", done, 1'b1);
        tick();
        mem_grant   = 1'b0;
        fetch_valid = 1'b0;
        settle();
        chk1("post_req", mem_req, 1'b0);
        chk1("post_upd", cache_update, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] ra;
        rst         = 1'b1;
        rdy_in      = 1'b1;
        flush       = 1'b0;
        fetch_valid = 1'b1;
        fetch_addr  = 32'h1234;
        mem_grant   = 1'b0;
        pre_we      = 1'b0;
        pre_addr    = 32'h0;
        pre_data    = 32'h0;
        #2;
        check_all_zero("reset");
        tick();
        tick();
        rst         = 1'b0;
        fetch_valid = 1'b0;
        tick();

        preload(32'h10, 32'h00A00093);
        do_fetch(32'h10, 0, 0, 0);

        do_fetch(32'h20, 1, 2, 0);
        tick();
        do_fetch(32'h20, 2, 0, 0);
        do_fetch(32'h20, 0, 0, 0);

        do_fetch(32'h40, 0, 1, 0);
        do_fetch(32'h40, 1, 0, 0);

        do_fetch(32'h60, 1, 0, 2);

        do_fetch(32'hFFFF_FFFE, 0, 0, 0);

        ra = 32'h100;
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 1) == 0 || i == 0)
                ra = 32'h100 + 32'(2 * $urandom_range(0, 47));
            do_fetch(ra, int'($urandom_range(0, 3)), 0,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
